// File: rtl/result_stream_source.sv
// Captures a frame of 64-bit results into a small buffer and emits each entry as
// an upper/lower 32-bit word pair on two independent Avalon-ST lanes.
module result_stream_source #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             reset_fifos,
  input  logic [CNT_W-1:0] n_samples,
  input  logic [63:0]      data_in,
  input  logic             data_in_valid,
  output logic [31:0]      up_data,
  output logic             up_valid,
  input  logic             up_ready,
  output logic [31:0]      down_data,
  output logic             down_valid,
  input  logic             down_ready,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [CNT_W-1:0] samples_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;

  state_t           state;
  logic             enable_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] in_cnt;
  logic [63:0]      mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             up_done;
  logic             down_done;

  logic             up_done_c;
  logic             down_done_c;
  logic             pop;
  logic             full;
  logic             accept;
  logic             push;
  logic             last_in;
  logic             start;
  logic [AW-1:0]    head_ptr;
  logic [AW:0]      rem;

  always_comb begin
    up_done_c   = up_done | (up_valid & up_ready);
    down_done_c = down_done | (down_valid & down_ready);
    pop         = (count != '0) & up_done_c & down_done_c;
    full        = (count == FULL_CNT);
    accept      = (state == CAPTURE) & data_in_valid;
    push        = accept & ~full;
    last_in     = accept & ((in_cnt + CNT_W'(1)) == len_q);
    start       = enable & ~enable_q;
    head_ptr    = rd_ptr + AW'(pop);
    rem         = count - (AW+1)'(pop);
  end

  // The soft clear deliberately leaves the edge detector alone so a held enable
  // does not restart a frame.
  always_ff @(posedge clk) begin
    if (!reset_n) enable_q <= 1'b0;
    else          enable_q <= enable;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  // Head words are reloaded from the post-pop pointer each cycle, so the next
  // entry is presented on the edge that pops the current one.
  always_ff @(posedge clk) begin
    if (!reset_n || reset_fifos) begin
      state       <= IDLE;
      len_q       <= '0;
      in_cnt      <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      up_done     <= 1'b0;
      down_done   <= 1'b0;
      up_valid    <= 1'b0;
      down_valid  <= 1'b0;
      up_data     <= '0;
      down_data   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      samples_out <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr     <= head_ptr;
      count      <= count + (AW+1)'(push) - (AW+1)'(pop);
      up_done    <= pop ? 1'b0 : up_done_c;
      down_done  <= pop ? 1'b0 : down_done_c;
      up_valid   <= (rem != '0) && (pop || !up_done_c);
      down_valid <= (rem != '0) && (pop || !down_done_c);
      if (rem != '0) begin
        up_data   <= mem[head_ptr][63:32];
        down_data <= mem[head_ptr][31:0];
      end
      if (pop) samples_out <= samples_out + CNT_W'(1);

      case (state)
        IDLE: begin
          if (start) begin
            len_q       <= n_samples;
            in_cnt      <= '0;
            samples_out <= '0;
            overflow    <= 1'b0;
            if (n_samples == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= CAPTURE;
              busy  <= 1'b1;
            end
          end
        end
        CAPTURE: begin
          if (accept) begin
            in_cnt <= in_cnt + CNT_W'(1);
            if (full) overflow <= 1'b1;
            if (last_in) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (count == '0 && !up_valid && !down_valid) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          if (!enable) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
